// File: rtl/runner_motion_ctrl.sv
// -----------------------------------------------------------------------------
// runner_motion_ctrl
//
// Player-motion controller for the runner game. Turns jump requests into a
// velocity/gravity trajectory. It also handles ground contact, walking off
// cliffs, multi-jump and falling out of the playfield, and it drives the
// run/jump/dead sprite animation.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   jump_btn     in   jump button level
//   jump_key     in   keyboard space-bar level (already decoded)
//   on_ground    in   terrain exists under the player (0 = cliff)
//   game_over    in   global freeze of all motion and timers
//   pos_x        out  [9:0]  constant horizontal position X0
//   pos_y        out  [9:0]  top of sprite, screen rows
//   vel          out  [7:0]  signed velocity, positive = up
//   airborne     out         state is RISE or FALL
//   land_pulse   out         one-cycle pulse on landing
//   fell_pulse   out         one-cycle pulse on entering DEAD
//   sprite_row   out  [2:0]  sprite-sheet row
//   sprite_col   out  [2:0]  sprite-sheet column
//   sprite_word  out  [31:0] {SPRITE_ID, 1'b0, pos_x, pos_y, row, col}
//   sprite_addr  out  [2:0]  sprite-table address (constant 0)
// -----------------------------------------------------------------------------
module runner_motion_ctrl #(
    parameter int         X0         = 80,
    parameter int         GROUND_Y   = 400,
    parameter int         MIN_Y      = 32,
    parameter int         FLOOR_Y    = 480,
    parameter int         TICK_DIV   = 250000,
    parameter int         V0         = 4,
    parameter int         VMAX       = 4,
    parameter int         G_DIV      = 2,
    parameter int         MAX_JUMPS  = 2,
    parameter int         COOLDOWN   = 500000,
    parameter int         NUM_FRAMES = 5,
    parameter int         FRAME_DIV  = 200000,
    parameter logic [4:0] SPRITE_ID  = 5'b10000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jump_btn,
    input  logic              jump_key,
    input  logic              on_ground,
    input  logic              game_over,
    output logic [9:0]        pos_x,
    output logic [9:0]        pos_y,
    output logic signed [7:0] vel,
    output logic              airborne,
    output logic              land_pulse,
    output logic              fell_pulse,
    output logic [2:0]        sprite_row,
    output logic [2:0]        sprite_col,
    output logic [31:0]       sprite_word,
    output logic [2:0]        sprite_addr
);

    // Motion states
    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_RISE   = 2'd1;
    localparam logic [1:0] ST_FALL   = 2'd2;
    localparam logic [1:0] ST_DEAD   = 2'd3;

    // Counter widths (never below 1 bit)
    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)      : 1;
    localparam int GW = (G_DIV     > 1) ? $clog2(G_DIV)         : 1;
    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV)     : 1;
    localparam int CW = (COOLDOWN  > 0) ? $clog2(COOLDOWN + 1)  : 1;
    localparam int JW = (MAX_JUMPS > 0) ? $clog2(MAX_JUMPS + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GRAV_LAST  = GW'(G_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
    localparam logic [CW-1:0] COOL_INIT  = CW'(COOLDOWN);
    localparam logic [JW-1:0] JUMP_MAX   = JW'(MAX_JUMPS);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_FRAMES - 1);

    localparam logic [9:0]        GROUND_P = 10'(GROUND_Y);
    localparam logic [9:0]        MIN_P    = 10'(MIN_Y);
    localparam logic [9:0]        FLOOR_P  = 10'(FLOOR_Y);
    localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
    localparam logic signed [10:0] MIN_S    = 11'(MIN_Y);
    localparam logic signed [10:0] FLOOR_S  = 11'(FLOOR_Y);
    localparam logic signed [7:0]  V0_S     = 8'(V0);
    localparam logic signed [7:0]  VEL_MIN  = 8'(-VMAX);

    // Registered state
    logic [1:0]    state;
    logic          req_r;
    logic          req_q;
    logic [JW-1:0] jumps_used;
    logic [CW-1:0] cooldown;
    logic [TW-1:0] tick_cnt;
    logic [GW-1:0] grav_cnt;
    logic [FW-1:0] frame_cnt;
    logic [2:0]    frame_idx;

    // Next-state values
    logic [1:0]        state_n;
    logic [9:0]        pos_n;
    logic signed [7:0] vel_n;
    logic [JW-1:0]     jumps_n;
    logic [CW-1:0]     cool_n;
    logic [TW-1:0]     tick_n;
    logic [GW-1:0]     grav_n;
    logic [FW-1:0]     fcnt_n;
    logic [2:0]        fidx_n;
    logic              land_n;
    logic              fell_n;
    logic [2:0]        row_n;
    logic [2:0]        col_n;
    logic              airborne_n;

    // Working values
    logic              req;
    logic              req_edge;
    logic              phys_tick;
    logic              accept;
    logic signed [10:0] y_next;
    logic signed [7:0]  vel_base;
    logic signed [7:0]  vel_grav;

    assign req       = jump_btn | jump_key;
    // The request is registered first, so the edge is one cycle behind the
    // input and the accept lands on the following clock edge.
    assign req_edge  = req_r & ~req_q;
    assign phys_tick = (tick_cnt == TICK_LAST);
    assign accept    = req_edge && !game_over && (state != ST_DEAD) &&
                       (jumps_used < JUMP_MAX) && (cooldown == '0);

    // Motion, timers and animation
    always_comb begin
        state_n  = state;
        pos_n    = pos_y;
        vel_n    = vel;
        jumps_n  = jumps_used;
        cool_n   = cooldown;
        tick_n   = tick_cnt;
        grav_n   = grav_cnt;
        fcnt_n   = frame_cnt;
        fidx_n   = frame_idx;
        land_n   = 1'b0;
        fell_n   = 1'b0;
        y_next   = $signed({1'b0, pos_y}) - $signed({{3{vel[7]}}, vel});
        vel_base = vel;
        vel_grav = vel;

        if (!game_over) begin
            tick_n = phys_tick ? '0 : tick_cnt + TW'(1);
            if (cooldown != '0) begin
                cool_n = cooldown - CW'(1);
            end

            // Run animation advances only while standing on the ground
            if (state == ST_GROUND) begin
                if (frame_cnt == FRAME_LAST) begin
                    fcnt_n = '0;
                    fidx_n = (frame_idx == IDX_LAST) ? 3'd0 : frame_idx + 3'd1;
                end else begin
                    fcnt_n = frame_cnt + FW'(1);
                end
            end

            if (accept) begin
                // A jump that coincides with a tick skips that tick's motion
                vel_n   = V0_S;
                state_n = ST_RISE;
                jumps_n = jumps_used + JW'(1);
                cool_n  = COOL_INIT;
                grav_n  = '0;
            end else if (phys_tick) begin
                case (state)
                    ST_GROUND: begin
                        if (!on_ground) begin
                            state_n = ST_FALL;
                            vel_n   = '0;
                            grav_n  = '0;
                        end
                    end
                    ST_RISE, ST_FALL: begin
                        if (state == ST_FALL && on_ground && pos_y <= GROUND_P &&
                            y_next >= GROUND_S) begin
                            pos_n   = GROUND_P;
                            vel_n   = '0;
                            jumps_n = '0;
                            state_n = ST_GROUND;
                            land_n  = 1'b1;
                        end else if (state == ST_FALL && !on_ground &&
                                     y_next >= FLOOR_S) begin
                            pos_n   = FLOOR_P;
                            vel_n   = '0;
                            state_n = ST_DEAD;
                            fell_n  = 1'b1;
                        end else begin
                            // Ceiling hit zeroes velocity before gravity acts
                            if (y_next < MIN_S) begin
                                pos_n    = MIN_P;
                                vel_base = '0;
                            end else begin
                                pos_n = y_next[9:0];
                            end
                            if (grav_cnt == GRAV_LAST) begin
                                grav_n   = '0;
                                vel_grav = (vel_base > VEL_MIN) ? vel_base - 8'sd1 : VEL_MIN;
                            end else begin
                                grav_n   = grav_cnt + GW'(1);
                                vel_grav = vel_base;
                            end
                            vel_n = vel_grav;
                            if (vel_grav <= 8'sd0) begin
                                state_n = ST_FALL;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sprite cell follows the state being entered so it never lags motion
    always_comb begin
        row_n      = '0;
        col_n      = '0;
        airborne_n = (state_n == ST_RISE) || (state_n == ST_FALL);
        if (!game_over) begin
            case (state_n)
                ST_GROUND: col_n = fidx_n;
                ST_RISE:   row_n = 3'd1;
                ST_FALL: begin
                    row_n = 3'd1;
                    col_n = 3'd1;
                end
                default: begin
                    row_n = 3'd1;
                    col_n = 3'd2;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_GROUND;
            req_r      <= 1'b0;
            req_q      <= 1'b0;
            pos_y      <= GROUND_P;
            vel        <= '0;
            jumps_used <= '0;
            cooldown   <= '0;
            tick_cnt   <= '0;
            grav_cnt   <= '0;
            frame_cnt  <= '0;
            frame_idx  <= '0;
            airborne   <= 1'b0;
            land_pulse <= 1'b0;
            fell_pulse <= 1'b0;
            sprite_row <= '0;
            sprite_col <= '0;
        end else begin
            state      <= state_n;
            req_r      <= req;
            req_q      <= req_r;
            pos_y      <= pos_n;
            vel        <= vel_n;
            jumps_used <= jumps_n;
            cooldown   <= cool_n;
            tick_cnt   <= tick_n;
            grav_cnt   <= grav_n;
            frame_cnt  <= fcnt_n;
            frame_idx  <= fidx_n;
            airborne   <= airborne_n;
            land_pulse <= land_n;
            fell_pulse <= fell_n;
            sprite_row <= row_n;
            sprite_col <= col_n;
        end
    end

    assign pos_x       = 10'(X0);
    assign sprite_addr = '0;
    assign sprite_word = {SPRITE_ID, 1'b0, pos_x, pos_y, sprite_row, sprite_col};

endmodule

// File: tb/tb_runner_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_runner_motion_ctrl
//
// Self-checking bench for runner_motion_ctrl with small timing parameters.
// A behavioural model (plain integer arithmetic on active-cycle counts) runs
// alongside the DUT; scenario tasks also compare against fixed trajectories.
// -----------------------------------------------------------------------------
module tb_runner_motion_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int G_DIV      = 2;
    localparam int V0         = 4;
    localparam int VMAX       = 4;
    localparam int COOLDOWN   = 8;
    localparam int MAX_JUMPS  = 2;
    localparam int NUM_FRAMES = 5;
    localparam int FRAME_DIV  = 3;
    localparam int GROUND_Y   = 400;
    localparam int MIN_Y      = 32;
    localparam int FLOOR_Y    = 480;

    localparam int S_GROUND = 0;
    localparam int S_RISE   = 1;
    localparam int S_FALL   = 2;
    localparam int S_DEAD   = 3;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic jump_btn  = 1'b0;
    logic jump_key  = 1'b0;
    logic on_ground = 1'b1;
    logic game_over = 1'b0;

    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic signed [7:0] vel;
    logic              airborne;
    logic              land_pulse;
    logic              fell_pulse;
    logic [2:0]        sprite_row;
    logic [2:0]        sprite_col;
    logic [31:0]       sprite_word;
    logic [2:0]        sprite_addr;
    logic [26:0]       dut_bundle;

    runner_motion_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .G_DIV     (G_DIV),
        .V0        (V0),
        .VMAX      (VMAX),
        .COOLDOWN  (COOLDOWN),
        .MAX_JUMPS (MAX_JUMPS),
        .NUM_FRAMES(NUM_FRAMES),
        .FRAME_DIV (FRAME_DIV)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .jump_btn   (jump_btn),
        .jump_key   (jump_key),
        .on_ground  (on_ground),
        .game_over  (game_over),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .vel        (vel),
        .airborne   (airborne),
        .land_pulse (land_pulse),
        .fell_pulse (fell_pulse),
        .sprite_row (sprite_row),
        .sprite_col (sprite_col),
        .sprite_word(sprite_word),
        .sprite_addr(sprite_addr)
    );

    always #5 clk = ~clk;

    assign dut_bundle = {pos_y, vel, airborne, land_pulse, fell_pulse, sprite_row, sprite_col};

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int m_state, m_y, m_vel, m_jumps, m_active, m_last_acc, m_grav, m_gcycles;
    int m_req_r, m_req_q, m_land, m_fell, m_row, m_col, m_moved;

    int exp_seq[18] = '{396, 392, 389, 386, 384, 382, 381, 380, 380,
                        380, 381, 382, 384, 386, 389, 392, 396, 400};

    // Advance the model by one clock using the current inputs, then clock the DUT
    task automatic step();
        int req, edge_seen, tk, acc, yn, v, was_ground, fidx;
        m_moved = 0;
        m_land  = 0;
        m_fell  = 0;
        if (reset) begin
            m_state = S_GROUND; m_y = GROUND_Y; m_vel = 0; m_jumps = 0;
            m_active = 0; m_last_acc = -1; m_grav = 0; m_gcycles = 0;
            m_req_r = 0; m_req_q = 0;
        end else begin
            req       = (jump_btn || jump_key) ? 1 : 0;
            edge_seen = (m_req_r == 1 && m_req_q == 0) ? 1 : 0;
            m_req_q   = m_req_r;
            m_req_r   = req;
            if (!game_over) begin
                tk  = ((m_active % TICK_DIV) == TICK_DIV - 1) ? 1 : 0;
                acc = (edge_seen == 1 && m_state != S_DEAD && m_jumps < MAX_JUMPS &&
                       (m_last_acc < 0 || m_active - m_last_acc > COOLDOWN)) ? 1 : 0;
                was_ground = (m_state == S_GROUND) ? 1 : 0;
                if (acc == 1) begin
                    m_vel = V0; m_state = S_RISE; m_jumps++; m_last_acc = m_active; m_grav = 0;
                end else if (tk == 1 && (m_state == S_RISE || m_state == S_FALL)) begin
                    m_moved = 1;
                    yn = m_y - m_vel;
                    if (m_state == S_FALL && on_ground && m_y <= GROUND_Y && yn >= GROUND_Y) begin
                        m_y = GROUND_Y; m_vel = 0; m_jumps = 0; m_state = S_GROUND; m_land = 1;
                    end else if (m_state == S_FALL && !on_ground && yn >= FLOOR_Y) begin
                        m_y = FLOOR_Y; m_vel = 0; m_state = S_DEAD; m_fell = 1;
                    end else begin
                        v = m_vel;
                        if (yn < MIN_Y) begin
                            yn = MIN_Y;
                            v  = 0;
                        end
                        m_y = yn;
                        m_grav++;
                        if (m_grav == G_DIV) begin
                            m_grav = 0;
                            v = (v - 1 < -VMAX) ? -VMAX : v - 1;
                        end
                        m_vel = v;
                        if (v <= 0) m_state = S_FALL;
                    end
                end else if (tk == 1 && m_state == S_GROUND && !on_ground) begin
                    m_state = S_FALL; m_vel = 0; m_grav = 0;
                end
                if (was_ground == 1) m_gcycles++;
                m_active++;
            end
        end
        fidx  = (m_gcycles / FRAME_DIV) % NUM_FRAMES;
        m_row = 0;
        m_col = 0;
        if (!reset && !game_over) begin
            case (m_state)
                S_GROUND: m_col = fidx;
                S_RISE:   m_row = 1;
                S_FALL:   begin m_row = 1; m_col = 1; end
                default:  begin m_row = 1; m_col = 2; end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] exp_bundle();
        logic air;
        air = (m_state == S_RISE || m_state == S_FALL);
        return {10'(m_y), 8'(m_vel), air, m_land[0], m_fell[0], 3'(m_row), 3'(m_col)};
    endfunction

    task automatic do_reset();
        reset = 1'b1; jump_btn = 1'b0; jump_key = 1'b0; on_ground = 1'b1; game_over = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] w;
        reset = 1'b1; jump_btn = 1'b0; jump_key = 1'b0; on_ground = 1'b1; game_over = 1'b0;
        repeat (2) step();
        w = {5'b10000, 1'b0, 10'd80, 10'd400, 3'd0, 3'd0};
        vectors++;
        if (dut_bundle !== exp_bundle()) begin
            miscompares++;
            $display("FAIL reset_state got=%h want=%h", dut_bundle, exp_bundle());
        end
        vectors++;
        if (sprite_word !== w) begin
            miscompares++;
            $display("FAIL reset_word got=%h want=%h", sprite_word, w);
        end
        vectors++;
        if (pos_x !== 10'd80 || sprite_addr !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_consts got x=%0d addr=%0d want x=80 addr=0", pos_x, sprite_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle_frames();
        logic [31:0] w;
        int ec;
        do_reset();
        for (int k = 1; k <= 45; k++) begin
            step();
            ec = (k / 3) % 5;
            w  = {5'b10000, 1'b0, 10'd80, 10'd400, 3'd0, 3'(ec)};
            vectors++;
            if (sprite_word !== w || dut_bundle !== exp_bundle()) begin
                miscompares++;
                $display("FAIL idle_frame k=%0d got word=%h want=%h", k, sprite_word, w);
            end
        end
    endtask

    task automatic test_single_jump();
        int q[$];
        int min_vel, land_seen, land_tick;
        min_vel = 0; land_seen = 0; land_tick = 0;
        do_reset();
        for (int c = 0; c < 300 && land_seen == 0; c++) begin
            jump_btn = (c < 2);
            step();
            vectors++;
            if (dut_bundle !== exp_bundle()) begin
                miscompares++;
                $display("FAIL jump_track c=%0d got=%h want=%h", c, dut_bundle, exp_bundle());
            end
            if (m_moved == 1) q.push_back(int'(pos_y));
            if (int'(vel) < min_vel) min_vel = int'(vel);
            if (land_pulse === 1'b1) begin
                land_seen = 1;
                land_tick = q.size();
            end
        end
        jump_btn = 1'b0;
        vectors++;
        if (land_seen == 0 || land_tick != 18) begin
            miscompares++;
            $display("FAIL jump_land got tick=%0d seen=%0d want tick=18", land_tick, land_seen);
        end
        for (int i = 0; i < 18 && i < q.size(); i++) begin
            vectors++;
            if (q[i] != exp_seq[i]) begin
                miscompares++;
                $display("FAIL jump_seq tick=%0d got=%0d want=%0d", i + 1, q[i], exp_seq[i]);
            end
        end
        vectors++;
        if (min_vel != -4) begin
            miscompares++;
            $display("FAIL jump_vmin got=%0d want=-4", min_vel);
        end
    endtask

    task automatic test_double_jump();
        int ok;
        do_reset();
        ok = 0;
        for (int c = 0; c < 200 && ok == 0; c++) begin
            jump_btn = (c < 2);
            step();
            vectors++;
            if (dut_bundle !== exp_bundle()) begin
                miscompares++;
                $display("FAIL dbl_rise c=%0d got=%h want=%h", c, dut_bundle, exp_bundle());
            end
            if (c > 4 && pos_y === 10'd380) ok = 1;
        end
        vectors++;
        if (ok == 0) begin
            miscompares++;
            $display("FAIL dbl_apex_timeout got=%0d want=380", pos_y);
        end
        jump_btn = 1'b1;
        repeat (2) step();
        jump_btn = 1'b0;
        vectors++;
        if (vel !== 8'sd4 || pos_y !== 10'd380 || dut_bundle !== exp_bundle()) begin
            miscompares++;
            $display("FAIL dbl_second got vel=%0d y=%0d want vel=4 y=380", vel, pos_y);
        end
        repeat (12) step();
        jump_key = 1'b1;
        repeat (2) step();
        jump_key = 1'b0;
        vectors++;
        if (vel === 8'sd4 || dut_bundle !== exp_bundle()) begin
            miscompares++;
            $display("FAIL dbl_third got vel=%0d want not 4 (model %0d)", vel, m_vel);
        end
        ok = 0;
        for (int c = 0; c < 400 && ok == 0; c++) begin
            step();
            vectors++;
            if (dut_bundle !== exp_bundle()) begin
                miscompares++;
                $display("FAIL dbl_fall c=%0d got=%h want=%h", c, dut_bundle, exp_bundle());
            end
            if (land_pulse === 1'b1) ok = 1;
        end
        vectors++;
        if (ok == 0) begin
            miscompares++;
            $display("FAIL dbl_land got=0 want=1");
        end
        jump_btn = 1'b1;
        repeat (2) step();
        jump_btn = 1'b0;
        vectors++;
        if (vel !== 8'sd4 || airborne !== 1'b1) begin
            miscompares++;
            $display("FAIL dbl_rearm got vel=%0d air=%0b want vel=4 air=1", vel, airborne);
        end
    endtask

    task automatic test_cooldown();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            jump_btn = (c < 2) || (c == 4) || (c == 5) || (c == 20) || (c == 21);
            step();
            vectors++;
            if (dut_bundle !== exp_bundle()) begin
                miscompares++;
                $display("FAIL cool_track c=%0d got=%h want=%h", c, dut_bundle, exp_bundle());
            end
            if (c == 21) begin
                vectors++;
                if (vel !== 8'sd4) begin
                    miscompares++;
                    $display("FAIL cool_third got vel=%0d want=4", vel);
                end
            end
        end
        jump_btn = 1'b0;
    endtask

    task automatic test_cliff();
        int fells, done;
        fells = 0; done = 0;
        do_reset();
        on_ground = 1'b0;
        for (int c = 0; c < 400 && done == 0; c++) begin
            step();
            vectors++;
            if (dut_bundle !== exp_bundle()) begin
                miscompares++;
                $display("FAIL cliff_track c=%0d got=%h want=%h", c, dut_bundle, exp_bundle());
            end
            if (fell_pulse === 1'b1) begin
                fells++;
                done = 1;
            end
        end
        for (int c = 0; c < 24; c++) begin
            jump_btn = c[1];
            step();
            if (fell_pulse === 1'b1) fells++;
        end
        jump_btn = 1'b0;
        vectors++;
        if (fells != 1 || pos_y !== 10'd480 || vel !== 8'sd0 || airborne !== 1'b0 ||
            sprite_row !== 3'd1 || sprite_col !== 3'd2) begin
            miscompares++;
            $display("FAIL cliff_dead got pulses=%0d y=%0d vel=%0d cell=%0d,%0d want 1 480 0 1,2",
                     fells, pos_y, vel, sprite_row, sprite_col);
        end
        on_ground = 1'b1;
    endtask

    task automatic test_game_over();
        int q[$];
        int ok;
        logic [9:0] py;
        logic signed [7:0] pv;
        do_reset();
        for (int c = 0; c < 100 && q.size() < 3; c++) begin
            jump_btn = (c < 2);
            step();
            if (m_moved == 1) q.push_back(int'(pos_y));
        end
        jump_btn  = 1'b0;
        py        = pos_y;
        pv        = vel;
        game_over = 1'b1;
        for (int c = 0; c < 20; c++) begin
            jump_btn = (c < 16) ? c[0] : 1'b0;
            step();
            vectors++;
            if (pos_y !== py || vel !== pv || sprite_row !== 3'd0 || sprite_col !== 3'd0 ||
                land_pulse !== 1'b0 || dut_bundle !== exp_bundle()) begin
                miscompares++;
                $display("FAIL freeze_hold c=%0d got y=%0d vel=%0d cell=%0d,%0d want y=%0d vel=%0d cell=0,0",
                         c, pos_y, vel, sprite_row, sprite_col, py, pv);
            end
        end
        game_over = 1'b0;
        jump_btn  = 1'b0;
        ok = 0;
        for (int c = 0; c < 300 && ok == 0; c++) begin
            step();
            vectors++;
            if (dut_bundle !== exp_bundle()) begin
                miscompares++;
                $display("FAIL freeze_resume c=%0d got=%h want=%h", c, dut_bundle, exp_bundle());
            end
            if (m_moved == 1) q.push_back(int'(pos_y));
            if (land_pulse === 1'b1) ok = 1;
        end
        vectors++;
        if (ok == 0 || q.size() != 18) begin
            miscompares++;
            $display("FAIL freeze_len got ticks=%0d want=18", q.size());
        end
        for (int i = 0; i < 18 && i < q.size(); i++) begin
            vectors++;
            if (q[i] != exp_seq[i]) begin
                miscompares++;
                $display("FAIL freeze_seq tick=%0d got=%0d want=%0d", i + 1, q[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic og;
        logic [31:0] w;
        og = 1'b1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) jump_btn = ~jump_btn;
            if ($urandom_range(0, 13) == 0) jump_key = ~jump_key;
            if ($urandom_range(0, 59) == 0) game_over = ~game_over;
            if ($urandom_range(0, 39) == 0) og = ~og;
            on_ground = (m_y > GROUND_Y) ? 1'b0 : og;
            step();
            w = {5'b10000, 1'b0, 10'd80, 10'(m_y), 3'(m_row), 3'(m_col)};
            vectors++;
            if (dut_bundle !== exp_bundle() || sprite_word !== w) begin
                miscompares++;
                $display("FAIL random c=%0d got=%h/%h want=%h/%h", c, dut_bundle, sprite_word,
                         exp_bundle(), w);
            end
        end
        reset = 1'b0; jump_btn = 1'b0; jump_key = 1'b0; game_over = 1'b0; on_ground = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle_frames();
        test_single_jump();
        test_double_jump();
        test_cooldown();
        test_cliff();
        test_game_over();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
